processor_control_unit: RTL and testbench
=========================================

PROCESSOR_CONTROL_UNIT -- requirements
Module: processor_control_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 16, width of opcode input and instr_count output.
REQ-002 Parameter ALU_OP, default 4'h1, top-nibble code for the ALU class.
REQ-003 Parameter ROM_OP, default 4'h3, top-nibble code for the ROM class.
REQ-004 Parameter RAM_OP, default 4'h4, top-nibble code for the RAM class.
REQ-005 Parameter PC_OP, default 4'h7, top-nibble code for the PC/branch class.
REQ-006 Parameter HALT_OP, default 4'hF, top-nibble code for halt.
REQ-007 Parameter TIMEOUT, default 8, maximum MEM_WAIT cycles before fault, valid range 1..255.
REQ-008 Port clk  in  1  sole clock, all state updates on the rising edge.
REQ-009 Port reset  in  1  asynchronous, active-low reset: 0 resets immediately, release is synchronous to clk.
REQ-010 Port run  in  1  start/resume request, sampled only in IDLE and HALT.
REQ-011 Port opcode  in  DATA_WIDTH  current instruction opcode word from ROM.
REQ-012 Port mem_ready  in  1  RAM access-complete handshake.
REQ-013 Port pc_read_enable  out  1  drives PC value onto data bus.
REQ-014 Port pc_enable  out  1  PC advance/load strobe.
REQ-015 Port alu_read_enable  out  1  ALU result onto data bus.
REQ-016 Port ram_read_enable  out  1  RAM read strobe.
REQ-017 Port ram_write_enable  out  1  RAM write strobe.
REQ-018 Port state  out  3  current state encoding.
REQ-019 Port halted  out  1  high in HALT.
REQ-020 Port fault  out  1  high in FAULT.
REQ-021 Port instr_count  out  DATA_WIDTH  retired-instruction counter.

Function
REQ-022 State encoding SHALL be IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEM_WAIT=4, WRITEBACK=5, HALT=6, FAULT=7.
REQ-023 IDLE SHALL go to FETCH on the edge where run=1; otherwise it stays in IDLE.
REQ-024 FETCH SHALL assert pc_read_enable and pc_enable for exactly one cycle, then go to DECODE.
REQ-025 DECODE SHALL latch opcode[DATA_WIDTH-1:DATA_WIDTH-4] as the class and opcode[DATA_WIDTH-5] as the write bit.
REQ-026 DECODE SHALL route ALU/ROM/PC classes to EXECUTE, RAM to MEM_WAIT, HALT_OP to HALT, and any other nibble to FAULT.
REQ-027 EXECUTE SHALL assert alu_read_enable for ALU class, pc_enable for PC class, and no strobe for ROM class, then go to WRITEBACK.
REQ-028 MEM_WAIT SHALL hold ram_write_enable (write bit=1) or ram_read_enable (write bit=0) high on every cycle in the state.
REQ-029 MEM_WAIT SHALL go to WRITEBACK on the first edge with mem_ready=1; the wait counter clears on entry.
REQ-030 If mem_ready stays 0 for TIMEOUT consecutive MEM_WAIT cycles, the block SHALL go to FAULT; mem_ready=1 on the TIMEOUT-th cycle takes priority (go to WRITEBACK).
REQ-031 WRITEBACK SHALL increment instr_count modulo 2^DATA_WIDTH (all-ones wraps to 0), then go to FETCH.
REQ-032 HALT SHALL assert halted, count nothing, and go to FETCH on run=1 (resume at the next PC).
REQ-033 FAULT SHALL assert fault and be left only by reset.
REQ-034 run SHALL be ignored in every state except IDLE and HALT.
REQ-035 All strobes SHALL be Moore outputs decoded from the registered state and latched class; each strobe is 0 outside the states named above.
REQ-036 Latency: a non-RAM instruction SHALL take 4 cycles (FETCH, DECODE, EXECUTE, WRITEBACK); a RAM instruction with N wait cycles SHALL take 3+N cycles, N>=1.
REQ-037 ram_read_enable and ram_write_enable SHALL never be high in the same cycle.

Reset
REQ-038 While reset=0: state=IDLE, all strobes=0, halted=0, fault=0, instr_count=0, class/write/wait registers=0.
REQ-039 Reset asserted mid-MEM_WAIT SHALL drop the RAM strobe immediately (asynchronously), without waiting for a clk edge.
REQ-040 The first edge after reset release with run=1 SHALL enter FETCH.

Verification
REQ-041 Reset release, run=1 pulse, opcode=16'h1000 -> states 1,2,3,5,1; alu_read_enable high only in state 3; instr_count=1 after WRITEBACK.
REQ-042 opcode=16'h4800, mem_ready high on the 3rd MEM_WAIT cycle -> ram_write_enable high for 3 cycles, then WRITEBACK, instr_count increments.
REQ-043 opcode=16'h4000, mem_ready held 0, TIMEOUT=8 -> ram_read_enable high for 8 cycles, then state=7, fault=1 held until reset.
REQ-044 opcode=16'hF000 -> state=6, halted=1, instr_count unchanged; run=1 -> FETCH next edge.
REQ-045 opcode=16'h2000 -> FAULT; instr_count preloaded to 16'hFFFF then an ALU op -> count wraps to 16'h0000.
REQ-046 reset=0 asserted during MEM_WAIT -> all outputs 0 and state=0 before the next clk edge.

Source files
------------

// File: rtl/processor_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : processor_control_unit
// Description : Multi-cycle instruction sequencer. Steps through
//               FETCH/DECODE/EXECUTE/WRITEBACK, waits on RAM with a bounded
//               handshake, and supports HALT/resume and a sticky FAULT state.
//               All strobes are Moore outputs of the registered state.
// Revision    : 1.0 - initial release
// ============================================================================
module processor_control_unit #(
    parameter int         DATA_WIDTH = 16,
    parameter logic [3:0] ALU_OP     = 4'h1,
    parameter logic [3:0] ROM_OP     = 4'h3,
    parameter logic [3:0] RAM_OP     = 4'h4,
    parameter logic [3:0] PC_OP      = 4'h7,
    parameter logic [3:0] HALT_OP    = 4'hF,
    parameter int         TIMEOUT    = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run,
    input  logic [DATA_WIDTH-1:0] opcode,
    input  logic                  mem_ready,
    output logic                  pc_read_enable,
    output logic                  pc_enable,
    output logic                  alu_read_enable,
    output logic                  ram_read_enable,
    output logic                  ram_write_enable,
    output logic [2:0]            state,
    output logic                  halted,
    output logic                  fault,
    output logic [DATA_WIDTH-1:0] instr_count
);

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_FETCH     = 3'd1;
    localparam logic [2:0] c_DECODE    = 3'd2;
    localparam logic [2:0] c_EXECUTE   = 3'd3;
    localparam logic [2:0] c_MEM_WAIT  = 3'd4;
    localparam logic [2:0] c_WRITEBACK = 3'd5;
    localparam logic [2:0] c_HALT      = 3'd6;
    localparam logic [2:0] c_FAULT     = 3'd7;

    // Wait counter value on the last permitted MEM_WAIT cycle (TIMEOUT is 1..255)
    localparam logic [7:0]            c_WAIT_LAST = 8'(TIMEOUT - 1);
    localparam logic [DATA_WIDTH-1:0] c_COUNT_ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

    logic [2:0]            r_state;
    logic [2:0]            w_next_state;
    logic [3:0]            r_class;
    logic                  r_write;
    logic [7:0]            r_wait;
    logic [DATA_WIDTH-1:0] r_instr_count;

    logic [3:0]            w_op_class;
    logic                  w_op_write;

    assign w_op_class = opcode[DATA_WIDTH-1 -: 4];
    assign w_op_write = opcode[DATA_WIDTH-5];

    // Operand bits below the write bit are not used by the sequencer
    generate
        if (DATA_WIDTH > 5) begin : g_unused_bits
            logic w_unused_low_bits;
            assign w_unused_low_bits = ^opcode[DATA_WIDTH-6:0];
        end
    endgenerate

    // State register; reset forces IDLE asynchronously so strobes drop at once
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= c_IDLE;
        else        r_state <= w_next_state;
    end

    // Capture instruction class and write bit while in DECODE
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_class <= 4'd0;
            r_write <= 1'b0;
        end else if (r_state == c_DECODE) begin
            r_class <= w_op_class;
            r_write <= w_op_write;
        end
    end

    // MEM_WAIT cycle counter, held at zero outside MEM_WAIT so it is clear on entry
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                     r_wait <= 8'd0;
        else if (r_state == c_MEM_WAIT) r_wait <= r_wait + 8'd1;
        else                            r_wait <= 8'd0;
    end

    // Retired-instruction counter, wraps naturally at 2^DATA_WIDTH
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                      r_instr_count <= '0;
        else if (r_state == c_WRITEBACK) r_instr_count <= r_instr_count + c_COUNT_ONE;
    end

    // Next-state decode; mem_ready beats the timeout on the final wait cycle
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:      if (run) w_next_state = c_FETCH;
            c_FETCH:     w_next_state = c_DECODE;
            c_DECODE: begin
                if (w_op_class == ALU_OP || w_op_class == ROM_OP || w_op_class == PC_OP)
                    w_next_state = c_EXECUTE;
                else if (w_op_class == RAM_OP)
                    w_next_state = c_MEM_WAIT;
                else if (w_op_class == HALT_OP)
                    w_next_state = c_HALT;
                else
                    w_next_state = c_FAULT;
            end
            c_EXECUTE:   w_next_state = c_WRITEBACK;
            c_MEM_WAIT: begin
                if (mem_ready)                 w_next_state = c_WRITEBACK;
                else if (r_wait == c_WAIT_LAST) w_next_state = c_FAULT;
            end
            c_WRITEBACK: w_next_state = c_FETCH;
            c_HALT:      if (run) w_next_state = c_FETCH;
            c_FAULT:     w_next_state = c_FAULT;
            default:     w_next_state = c_FAULT;
        endcase
    end

    // Moore strobes from registered state and latched class
    always_comb begin
        pc_read_enable   = 1'b0;
        pc_enable        = 1'b0;
        alu_read_enable  = 1'b0;
        ram_read_enable  = 1'b0;
        ram_write_enable = 1'b0;
        case (r_state)
            c_FETCH: begin
                pc_read_enable = 1'b1;
                pc_enable      = 1'b1;
            end
            c_EXECUTE: begin
                alu_read_enable = (r_class == ALU_OP);
                pc_enable       = (r_class == PC_OP);
            end
            c_MEM_WAIT: begin
                ram_write_enable = r_write;
                ram_read_enable  = ~r_write;
            end
            default: ;
        endcase
    end

    assign state       = r_state;
    assign halted      = (r_state == c_HALT);
    assign fault       = (r_state == c_FAULT);
    assign instr_count = r_instr_count;

endmodule
`default_nettype wire

// File: tb/tb_processor_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_processor_control_unit
// Description : Self-checking bench for processor_control_unit. A trace model
//               expands each instruction into its expected per-cycle outputs.
//               A second 8-bit instance exercises counter wrap and a short
//               timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_processor_control_unit;

    localparam int TO = 8;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, run, mem_ready;
    logic [15:0] opcode;
    logic        pc_read_enable, pc_enable, alu_read_enable, ram_read_enable, ram_write_enable;
    logic [2:0]  state;
    logic        halted, fault;
    logic [15:0] instr_count;

    logic        reset8, run8, mem_ready8;
    logic [7:0]  opcode8;
    logic        pc_rd_8, pc_en_8, alu_rd_8, ram_rd_8, ram_wr_8;
    logic [2:0]  state_8;
    logic        halted_8, fault_8;
    logic [7:0]  instr_count_8;

    processor_control_unit #(.DATA_WIDTH(16), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .run(run), .opcode(opcode), .mem_ready(mem_ready),
        .pc_read_enable(pc_read_enable), .pc_enable(pc_enable),
        .alu_read_enable(alu_read_enable), .ram_read_enable(ram_read_enable),
        .ram_write_enable(ram_write_enable), .state(state), .halted(halted),
        .fault(fault), .instr_count(instr_count)
    );

    processor_control_unit #(.DATA_WIDTH(8), .TIMEOUT(3)) dut8 (
        .clk(clk), .reset(reset8), .run(run8), .opcode(opcode8), .mem_ready(mem_ready8),
        .pc_read_enable(pc_rd_8), .pc_enable(pc_en_8),
        .alu_read_enable(alu_rd_8), .ram_read_enable(ram_rd_8),
        .ram_write_enable(ram_wr_8), .state(state_8), .halted(halted_8),
        .fault(fault_8), .instr_count(instr_count_8)
    );

    logic [6:0] obs_flags;
    assign obs_flags = {pc_read_enable, pc_enable, alu_read_enable,
                        ram_read_enable, ram_write_enable, halted, fault};

    int checks = 0;
    int errors = 0;

    // Expected per-cycle observation; flags = {pc_rd, pc_en, alu_rd, ram_rd, ram_wr, halted, fault}
    typedef struct packed {
        logic [2:0]  st;
        logic [6:0]  flags;
        logic        ready;
        logic [15:0] cnt;
    } exp_t;

    exp_t        q[$];
    logic [15:0] m_count;

    function automatic exp_t mk(input logic [2:0] st, input logic [6:0] fl,
                                input logic rdy, input logic [15:0] c);
        exp_t e;
        e.st = st; e.flags = fl; e.ready = rdy; e.cnt = c;
        return e;
    endfunction

    // Expand one instruction into its expected cycle trace from the class rules
    task automatic build(input logic [15:0] op, input int ready_at);
        logic [3:0] cls;
        logic       wr;
        int         n;
        bit         served;
        cls = op[15:12];
        wr  = op[11];
        served = (ready_at >= 1 && ready_at <= TO);
        q.delete();
        q.push_back(mk(3'd1, 7'b1100000, 1'b0, m_count));
        q.push_back(mk(3'd2, 7'b0000000, 1'b0, m_count));
        if (cls == 4'h1 || cls == 4'h3 || cls == 4'h7) begin
            q.push_back(mk(3'd3, {1'b0, cls == 4'h7, cls == 4'h1, 4'b0000}, 1'b0, m_count));
            q.push_back(mk(3'd5, 7'b0000000, 1'b0, m_count));
            m_count = m_count + 16'd1;
        end else if (cls == 4'h4) begin
            n = served ? ready_at : TO;
            for (int j = 1; j <= n; j++)
                q.push_back(mk(3'd4, {3'b000, ~wr, wr, 2'b00}, (j == ready_at), m_count));
            if (served) begin
                q.push_back(mk(3'd5, 7'b0000000, 1'b0, m_count));
                m_count = m_count + 16'd1;
            end else begin
                q.push_back(mk(3'd7, 7'b0000001, 1'b0, m_count));
            end
        end else if (cls == 4'hF) begin
            q.push_back(mk(3'd6, 7'b0000010, 1'b0, m_count));
        end else begin
            q.push_back(mk(3'd7, 7'b0000001, 1'b0, m_count));
        end
    endtask

    // Walk the trace at negedges; run and mem_ready are randomised wherever they must be ignored
    task automatic exec_trace(input string name);
        foreach (q[i]) begin
            checks++;
            if ({state, obs_flags, instr_count} !== {q[i].st, q[i].flags, q[i].cnt}) begin
                errors++;
                $display("FAIL %s step %0d: got state=%0d flags=%b count=%h, expected state=%0d flags=%b count=%h",
                         name, i, state, obs_flags, instr_count, q[i].st, q[i].flags, q[i].cnt);
            end
            mem_ready = (q[i].st == 3'd4) ? q[i].ready : 1'($urandom);
            run       = (q[i].st == 3'd6) ? 1'b0 : 1'($urandom);
            @(negedge clk);
        end
        run = 1'b0;
        mem_ready = 1'b0;
    endtask

    task automatic run_instr(input string name, input logic [15:0] op, input int ready_at);
        opcode = op;
        build(op, ready_at);
        exec_trace(name);
    endtask

    task automatic start_run();
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; run = 1'b0; mem_ready = 1'b0;
        #1;
        checks++;
        if ({state, obs_flags, instr_count} !== 26'd0) begin
            errors++;
            $display("FAIL reset_hold: got state=%0d flags=%b count=%h, expected all zero",
                     state, obs_flags, instr_count);
        end
        @(negedge clk);
        reset = 1'b1;
        m_count = 16'd0;
        for (int i = 0; i < 2; i++) begin
            mem_ready = 1'($urandom);
            @(negedge clk);
            checks++;
            if ({state, obs_flags, instr_count} !== 26'd0) begin
                errors++;
                $display("FAIL reset_idle: got state=%0d flags=%b count=%h, expected idle zeros",
                         state, obs_flags, instr_count);
            end
        end
        mem_ready = 1'b0;
    endtask

    task automatic test_alu();
        start_run();
        run_instr("alu", 16'h1000, 0);
        checks++;
        if (instr_count !== 16'd1 || state !== 3'd1) begin
            errors++;
            $display("FAIL alu_retire: got count=%h state=%0d, expected count=0001 state=1",
                     instr_count, state);
        end
    endtask

    task automatic test_rom_pc();
        run_instr("rom", 16'h3A5C, 0);
        run_instr("pc", 16'h7123, 0);
    endtask

    task automatic test_ram_write();
        run_instr("ram_write", 16'h4800, 3);
    endtask

    task automatic test_ready_at_timeout();
        run_instr("ready_last_cycle", 16'h4000, TO);
    endtask

    task automatic resume_from_halt(input string name);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (state !== 3'd6 || halted !== 1'b1 || instr_count !== m_count) begin
                errors++;
                $display("FAIL %s hold: got state=%0d halted=%b count=%h, expected state=6 halted=1 count=%h",
                         name, state, halted, instr_count, m_count);
            end
            mem_ready = 1'($urandom);
            @(negedge clk);
        end
        mem_ready = 1'b0;
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        checks++;
        if (state !== 3'd1) begin
            errors++;
            $display("FAIL %s resume: got state=%0d, expected 1", name, state);
        end
    endtask

    task automatic test_halt();
        run_instr("halt", 16'hF000, 0);
        resume_from_halt("halt");
    endtask

    task automatic check_fault_sticky(input string name);
        for (int i = 0; i < 4; i++) begin
            run = 1'($urandom);
            mem_ready = 1'($urandom);
            @(negedge clk);
            checks++;
            if (state !== 3'd7 || obs_flags !== 7'b0000001) begin
                errors++;
                $display("FAIL %s sticky: got state=%0d flags=%b, expected state=7 flags=0000001",
                         name, state, obs_flags);
            end
        end
        run = 1'b0;
        mem_ready = 1'b0;
    endtask

    task automatic test_ram_timeout();
        run_instr("ram_timeout", 16'h4000, 0);
        check_fault_sticky("ram_timeout");
        test_reset();
    endtask

    task automatic test_illegal();
        start_run();
        run_instr("illegal", 16'h2000, 0);
        check_fault_sticky("illegal");
        test_reset();
    endtask

    task automatic test_reset_mid_wait();
        start_run();
        opcode = 16'h4000;
        mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (state !== 3'd4 || ram_read_enable !== 1'b1) begin
            errors++;
            $display("FAIL mid_wait_pre: got state=%0d ram_rd=%b, expected state=4 ram_rd=1",
                     state, ram_read_enable);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({state, obs_flags, instr_count} !== 26'd0) begin
            errors++;
            $display("FAIL mid_wait_async: got state=%0d flags=%b count=%h, expected all zero",
                     state, obs_flags, instr_count);
        end
        test_reset();
    endtask

    task automatic test_random();
        logic [15:0] op;
        int          kind;
        start_run();
        for (int k = 0; k < 40; k++) begin
            kind = $urandom_range(0, 8);
            case (kind)
                0, 1, 2: op = {4'h1, 12'($urandom)};
                3:       op = {4'h3, 12'($urandom)};
                4:       op = {4'h7, 12'($urandom)};
                8:       op = {4'hF, 12'($urandom)};
                default: op = {4'h4, 12'($urandom)};
            endcase
            run_instr("random", op, (op[15:12] == 4'h4) ? $urandom_range(1, TO) : 0);
            if (op[15:12] == 4'hF) resume_from_halt("random_halt");
        end
    endtask

    task automatic test_wrap();
        opcode8 = 8'h10;
        mem_ready8 = 1'b0;
        reset8 = 1'b1;
        run8 = 1'b1;
        @(negedge clk);
        run8 = 1'b0;
        repeat (4 * 255) @(negedge clk);
        checks++;
        if (instr_count_8 !== 8'hFF || state_8 !== 3'd1) begin
            errors++;
            $display("FAIL wrap_allones: got count=%h state=%0d, expected count=ff state=1",
                     instr_count_8, state_8);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (instr_count_8 !== 8'h00 || state_8 !== 3'd1) begin
            errors++;
            $display("FAIL wrap_zero: got count=%h state=%0d, expected count=00 state=1",
                     instr_count_8, state_8);
        end
        opcode8 = 8'h40;
        @(negedge clk);
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            checks++;
            if (state_8 !== 3'd4 || ram_rd_8 !== 1'b1 || ram_wr_8 !== 1'b0) begin
                errors++;
                $display("FAIL short_timeout_wait %0d: got state=%0d rd=%b wr=%b, expected state=4 rd=1 wr=0",
                         j, state_8, ram_rd_8, ram_wr_8);
            end
        end
        @(negedge clk);
        checks++;
        if (state_8 !== 3'd7 || fault_8 !== 1'b1 || ram_rd_8 !== 1'b0) begin
            errors++;
            $display("FAIL short_timeout_fault: got state=%0d fault=%b rd=%b, expected state=7 fault=1 rd=0",
                     state_8, fault_8, ram_rd_8);
        end
    endtask

    initial begin
        reset = 1'b0; run = 1'b0; mem_ready = 1'b0; opcode = 16'h0000;
        reset8 = 1'b0; run8 = 1'b0; mem_ready8 = 1'b0; opcode8 = 8'h00;
        m_count = 16'd0;
        @(negedge clk);
        test_reset();
        test_alu();
        test_rom_pc();
        test_ram_write();
        test_ready_at_timeout();
        test_halt();
        test_ram_timeout();
        test_illegal();
        test_reset_mid_wait();
        test_random();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
